// File: rtl/flash_monitor_pkg.sv
// Shared status codes and default timing for the lamp flash monitor,
// so the intersection controller decodes status the same way.
package flash_monitor_pkg;

    typedef enum logic [2:0] {
        ST_STEADY_OFF = 3'd0,
        ST_STEADY_ON  = 3'd1,
        ST_ACQUIRE    = 3'd2,
        ST_FLASHING   = 3'd3,
        ST_FAULT      = 3'd4
    } status_t;

    localparam logic [31:0] DEFAULT_HALF_PERIOD  = 32'd50000001;
    localparam logic [31:0] DEFAULT_TOLERANCE    = 32'd1000;
    localparam logic [31:0] DEFAULT_STEADY_LIMIT = 32'd100000002;

    function automatic status_t steady_code(input logic level);
        return level ? ST_STEADY_ON : ST_STEADY_OFF;
    endfunction

endpackage

// File: rtl/flash_monitor_if.sv
// Lamp line plus supervision outputs; master drives the lamp line,
// slave is the monitor that reports on it.
interface flash_monitor_if;
    logic        light_in;
    logic [2:0]  status;
    logic        flashing;
    logic        fault_pulse;
    logic        measure_valid;
    logic [31:0] last_half;

    modport master (
        output light_in,
        input  status, flashing, fault_pulse, measure_valid, last_half
    );

    modport slave (
        input  light_in,
        output status, flashing, fault_pulse, measure_valid, last_half
    );
endinterface

// File: rtl/flash_monitor_sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous lamp line, followed by a
// history register so any level change shows up as a one-cycle edge.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level_q,
    output logic edge_det
);
    logic meta;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta    <= 1'b0;
            level_q <= 1'b0;
            prev    <= 1'b0;
        end else begin
            meta    <= async_in;
            level_q <= meta;
            prev    <= level_q;
        end
    end

    assign edge_det = level_q ^ prev;
endmodule

// File: rtl/flash_monitor.sv
// Measures each level of the lamp line and classifies it as steady,
// acquiring, flashing at the expected rate, or faulty.
module flash_monitor
    import flash_monitor_pkg::*;
#(
    parameter logic [31:0] HALF_PERIOD  = DEFAULT_HALF_PERIOD,
    parameter logic [31:0] TOLERANCE    = DEFAULT_TOLERANCE,
    parameter logic [31:0] STEADY_LIMIT = DEFAULT_STEADY_LIMIT
) (
    input  logic           clock,
    input  logic           reset,
    flash_monitor_if.slave mon
);
    localparam logic [31:0] WIN_LO = HALF_PERIOD - TOLERANCE;
    localparam logic [31:0] WIN_HI = HALF_PERIOD + TOLERANCE;

    logic        level_q;
    logic        edge_det;
    logic [31:0] run_len;
    logic [1:0]  good_cnt;
    logic [1:0]  good_next;
    status_t     state;
    status_t     state_next;
    logic        in_window;
    logic        saturated;
    logic        flashing_q;
    logic        fault_pulse_q;
    logic        measure_valid_q;
    logic [31:0] last_half_q;

    sync_edge_detect u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (mon.light_in),
        .level_q  (level_q),
        .edge_det (edge_det)
    );

    assign in_window = (run_len >= WIN_LO) && (run_len <= WIN_HI);
    assign saturated = (run_len == STEADY_LIMIT);

    // Edges win over saturation; a steady run before acquisition is not judged.
    always_comb begin
        state_next = state;
        good_next  = good_cnt;
        unique case (state)
            ST_STEADY_OFF, ST_STEADY_ON: begin
                if (edge_det) begin
                    state_next = ST_ACQUIRE;
                    good_next  = 2'd0;
                end
            end
            ST_ACQUIRE: begin
                if (edge_det) begin
                    if (in_window) begin
                        good_next = good_cnt + 2'd1;
                        if (good_cnt >= 2'd1) begin
                            state_next = ST_FLASHING;
                        end
                    end else begin
                        state_next = ST_FAULT;
                    end
                end else if (saturated) begin
                    state_next = steady_code(level_q);
                end
            end
            ST_FLASHING: begin
                if (edge_det) begin
                    if (!in_window) begin
                        state_next = ST_FAULT;
                    end
                end else if (saturated) begin
                    state_next = steady_code(level_q);
                end
            end
            ST_FAULT: begin
                if (!edge_det && saturated) begin
                    state_next = steady_code(level_q);
                end
            end
            default: begin
                state_next = ST_STEADY_OFF;
                good_next  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_STEADY_OFF;
            good_cnt        <= 2'd0;
            run_len         <= 32'd0;
            flashing_q      <= 1'b0;
            fault_pulse_q   <= 1'b0;
            measure_valid_q <= 1'b0;
            last_half_q     <= 32'd0;
        end else begin
            state           <= state_next;
            good_cnt        <= good_next;
            flashing_q      <= (state_next == ST_FLASHING);
            fault_pulse_q   <= (state_next == ST_FAULT) && (state != ST_FAULT);
            measure_valid_q <= edge_det;
            if (edge_det) begin
                last_half_q <= run_len;
                run_len     <= 32'd1;
            end else if (run_len < STEADY_LIMIT) begin
                run_len <= run_len + 32'd1;
            end
        end
    end

    assign mon.status        = state;
    assign mon.flashing      = flashing_q;
    assign mon.fault_pulse   = fault_pulse_q;
    assign mon.measure_valid = measure_valid_q;
    assign mon.last_half     = last_half_q;
endmodule
